// File: rtl/rv32_hazard_unit_if.sv
// Hazard-control bundle between the RV32 pipeline stages and rv32_hazard_unit.
// The master side is the pipeline, which drives status and receives stall/flush controls.
interface rv32_hazard_unit_if;
    logic [4:0] decode_rs1_unreg_in;
    logic       decode_rs1_read_unreg_in;
    logic [4:0] decode_rs2_unreg_in;
    logic       decode_rs2_read_unreg_in;
    logic       decode_mem_fence_unreg_in;
    logic [4:0] execute_rd_in;
    logic       execute_rd_write_in;
    logic       execute_mem_read_in;
    logic [4:0] mem_rd_in;
    logic       mem_rd_write_in;
    logic       execute_branch_mispredicted_in;
    logic       mem_busy_in;

    logic       fetch_stall_out;
    logic       fetch_flush_out;
    logic       decode_stall_out;
    logic       decode_flush_out;
    logic       execute_stall_out;
    logic       execute_flush_out;
    logic       mem_stall_out;
    logic       fence_active_out;

    modport master (
        output decode_rs1_unreg_in, decode_rs1_read_unreg_in,
        output decode_rs2_unreg_in, decode_rs2_read_unreg_in,
        output decode_mem_fence_unreg_in,
        output execute_rd_in, execute_rd_write_in, execute_mem_read_in,
        output mem_rd_in, mem_rd_write_in,
        output execute_branch_mispredicted_in, mem_busy_in,
        input  fetch_stall_out, fetch_flush_out,
        input  decode_stall_out, decode_flush_out,
        input  execute_stall_out, execute_flush_out,
        input  mem_stall_out, fence_active_out
    );

    modport slave (
        input  decode_rs1_unreg_in, decode_rs1_read_unreg_in,
        input  decode_rs2_unreg_in, decode_rs2_read_unreg_in,
        input  decode_mem_fence_unreg_in,
        input  execute_rd_in, execute_rd_write_in, execute_mem_read_in,
        input  mem_rd_in, mem_rd_write_in,
        input  execute_branch_mispredicted_in, mem_busy_in,
        output fetch_stall_out, fetch_flush_out,
        output decode_stall_out, decode_flush_out,
        output execute_stall_out, execute_flush_out,
        output mem_stall_out, fence_active_out
    );
endinterface

// File: rtl/rv32_hazard_unit.sv
// Stall/flush sequencer for the 5-stage in-order RV32 pipeline, with a FENCE drain FSM.
// Define RV32_FORWARDING_EN when EX->EX and MEM->EX bypass paths exist (only load-use stalls).
module rv32_hazard_unit #(
    parameter int DRAIN_CYCLES = 3
) (
    input logic               clk,
    input logic               reset,
    rv32_hazard_unit_if.slave hz
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

    if (DRAIN_CYCLES < 1) begin : g_bad_param
        $error("rv32_hazard_unit: DRAIN_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] drain_cnt, drain_cnt_n;

    logic raw_ex, raw_mem, load_use, data_hazard, fence_stall;
    logic fetch_stall, fetch_flush, decode_stall, decode_flush;
    logic execute_stall, execute_flush, mem_stall, fence_active;

    // x0 reads never create a dependency, hence the rd != 0 qualifiers.
    always_comb begin
        raw_ex = hz.execute_rd_write_in && (hz.execute_rd_in != 5'd0) &&
                 ((hz.decode_rs1_read_unreg_in && (hz.decode_rs1_unreg_in == hz.execute_rd_in)) ||
                  (hz.decode_rs2_read_unreg_in && (hz.decode_rs2_unreg_in == hz.execute_rd_in)));
        raw_mem = hz.mem_rd_write_in && (hz.mem_rd_in != 5'd0) &&
                  ((hz.decode_rs1_read_unreg_in && (hz.decode_rs1_unreg_in == hz.mem_rd_in)) ||
                   (hz.decode_rs2_read_unreg_in && (hz.decode_rs2_unreg_in == hz.mem_rd_in)));
        load_use = hz.execute_mem_read_in && raw_ex;
    end

`ifdef RV32_FORWARDING_EN
    assign data_hazard = load_use;
`else
    // Writeback is never checked: the register file writes through.
    assign data_hazard = raw_ex || raw_mem;
`endif

    assign fence_stall = (state == DRAIN) ||
                         ((state == IDLE) && hz.decode_mem_fence_unreg_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        drain_cnt_n   = drain_cnt;
        fetch_stall   = 1'b0;
        fetch_flush   = 1'b0;
        decode_stall  = 1'b0;
        decode_flush  = 1'b0;
        execute_stall = 1'b0;
        execute_flush = 1'b0;
        mem_stall     = 1'b0;
        fence_active  = (state != IDLE);

        if (reset) begin
            fetch_flush   = 1'b1;
            decode_flush  = 1'b1;
            execute_flush = 1'b1;
            fence_active  = 1'b0;
        end else if (hz.mem_busy_in) begin
            // Whole pipe freezes; the FSM and drain counter hold with it.
            fetch_stall   = 1'b1;
            decode_stall  = 1'b1;
            execute_stall = 1'b1;
            mem_stall     = 1'b1;
        end else if (hz.execute_branch_mispredicted_in) begin
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
            state_n      = IDLE;
            drain_cnt_n  = '0;
        end else begin
            if (data_hazard || fence_stall) begin
                fetch_stall  = 1'b1;
                decode_flush = 1'b1;
            end
            unique case (state)
                IDLE: begin
                    // A fence that is also load-use dependent still starts draining.
                    if (hz.decode_mem_fence_unreg_in) begin
                        state_n     = DRAIN;
                        drain_cnt_n = CNT_INIT;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state_n = RELEASE;
                    else                 drain_cnt_n = drain_cnt - 1'b1;
                end
                RELEASE: begin
                    // The fence only leaves decode when no data hazard holds it back.
                    if (!data_hazard) state_n = IDLE;
                end
                default: begin
                    state_n     = IDLE;
                    drain_cnt_n = '0;
                end
            endcase
        end
    end

    assign hz.fetch_stall_out   = fetch_stall;
    assign hz.fetch_flush_out   = fetch_flush;
    assign hz.decode_stall_out  = decode_stall;
    assign hz.decode_flush_out  = decode_flush;
    assign hz.execute_stall_out = execute_stall;
    assign hz.execute_flush_out = execute_flush;
    assign hz.mem_stall_out     = mem_stall;
    assign hz.fence_active_out  = fence_active;
endmodule

// File: tb/tb_rv32_hazard_unit.sv
// Directed, table-driven bench for rv32_hazard_unit plus hand-written FENCE/reset sequences.
module tb_rv32_hazard_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32_hazard_unit_if hz();
    rv32_hazard_unit #(.DRAIN_CYCLES(3)) dut (.clk(clk), .reset(reset), .hz(hz.slave));

    // Observed vector: {fstall, fflush, dstall, dflush, estall, eflush, mstall, fence_active}
    logic [7:0] outv;
    assign outv = {hz.fetch_stall_out, hz.fetch_flush_out, hz.decode_stall_out,
                   hz.decode_flush_out, hz.execute_stall_out, hz.execute_flush_out,
                   hz.mem_stall_out, hz.fence_active_out};

    localparam logic [7:0] NONE = 8'h00;
    localparam logic [7:0] HZ   = 8'h90;
    localparam logic [7:0] BUSY = 8'hAA;
    localparam logic [7:0] MISP = 8'h50;
    localparam logic [7:0] RST  = 8'h54;
    localparam logic [7:0] FA   = 8'h01;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [4:0] rs1; logic r1; logic [4:0] rs2; logic r2;
        logic [4:0] exrd; logic exwr; logic exld;
        logic [4:0] mrd; logic mwr;
        logic       misp; logic busy;
        logic [7:0] exp_nf; logic [7:0] exp_fw;
    } vec_t;

    vec_t vt[13];

    task automatic drive(input logic [4:0] rs1, input logic r1, input logic [4:0] rs2,
                         input logic r2, input logic fence, input logic [4:0] exrd,
                         input logic exwr, input logic exld, input logic [4:0] mrd,
                         input logic mwr, input logic misp, input logic busy);
        hz.decode_rs1_unreg_in            = rs1;
        hz.decode_rs1_read_unreg_in       = r1;
        hz.decode_rs2_unreg_in            = rs2;
        hz.decode_rs2_read_unreg_in       = r2;
        hz.decode_mem_fence_unreg_in      = fence;
        hz.execute_rd_in                  = exrd;
        hz.execute_rd_write_in            = exwr;
        hz.execute_mem_read_in            = exld;
        hz.mem_rd_in                      = mrd;
        hz.mem_rd_write_in                = mwr;
        hz.execute_branch_mispredicted_in = misp;
        hz.mem_busy_in                    = busy;
    endtask

    task automatic idle_in(input logic fence);
        drive(5'd0, 1'b0, 5'd0, 1'b0, fence, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare in the middle of the cycle, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [7:0] exp);
        @(negedge clk);
        n_cmp++;
        if (outv !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, outv, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{"quiet",        5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE, NONE};
        vt[1]  = '{"load_use_rs1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, HZ,   HZ};
        vt[2]  = '{"load_x0",      5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NONE, NONE};
        vt[3]  = '{"alu_ex_rs1",   5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, HZ,   NONE};
        vt[4]  = '{"alu_mem_rs2",  5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, HZ,   NONE};
        vt[5]  = '{"mem_rs2_noread",5'd0,1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, NONE, NONE};
        vt[6]  = '{"load_use_rs2", 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, HZ,   HZ};
        vt[7]  = '{"load_nowrite", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NONE, NONE};
        vt[8]  = '{"busy_loaduse", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, BUSY, BUSY};
        vt[9]  = '{"misp_loaduse", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, MISP, MISP};
        vt[10] = '{"busy_misp",    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, BUSY, BUSY};
        vt[11] = '{"mem_x0",       5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, NONE, NONE};
        vt[12] = '{"load_nomatch", 5'd4, 1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NONE, NONE};

        // Reset held two cycles, then released.
        reset = 1'b1;
        idle_in(1'b0);
        #1;
        cyc("reset_c0", RST);
        cyc("reset_c1", RST);
        reset = 1'b0;
        cyc("post_reset", NONE);

        // Combinational vectors, all applied with the FSM in IDLE.
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rs1, vt[i].r1, vt[i].rs2, vt[i].r2, 1'b0, vt[i].exrd, vt[i].exwr,
                  vt[i].exld, vt[i].mrd, vt[i].mwr, vt[i].misp, vt[i].busy);
`ifdef RV32_FORWARDING_EN
            cyc(vt[i].name, vt[i].exp_fw);
`else
            cyc(vt[i].name, vt[i].exp_nf);
`endif
        end

        // Load-use lasts exactly one cycle once the dependency leaves execute.
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("lu_seq_stall", HZ);
        idle_in(1'b0);
        cyc("lu_seq_clear", NONE);

        // Plain fence: 1 IDLE + 3 DRAIN stall cycles, 1 RELEASE, back to IDLE.
        idle_in(1'b1);
        cyc("fence_idle", HZ);
        cyc("fence_drain2", HZ | FA);
        cyc("fence_drain1", HZ | FA);
        cyc("fence_drain0", HZ | FA);
        cyc("fence_release", FA);
        idle_in(1'b0);
        cyc("fence_done", NONE);

        // mem_busy freezes the drain counter at 1 for three cycles.
        idle_in(1'b1);
        cyc("busy_f_idle", HZ);
        cyc("busy_f_drain2", HZ | FA);
        hz.mem_busy_in = 1'b1;
        cyc("busy_hold0", BUSY | FA);
        cyc("busy_hold1", BUSY | FA);
        cyc("busy_hold2", BUSY | FA);
        hz.mem_busy_in = 1'b0;
        cyc("busy_f_drain1", HZ | FA);
        cyc("busy_f_drain0", HZ | FA);
        cyc("busy_f_release", FA);
        idle_in(1'b0);
        cyc("busy_f_done", NONE);

        // Fence that is also load-use dependent; data hazard holds it in RELEASE.
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("lu_fence_idle", HZ);
        idle_in(1'b1);
        cyc("lu_fence_drain2", HZ | FA);
        cyc("lu_fence_drain1", HZ | FA);
        cyc("lu_fence_drain0", HZ | FA);
        drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("release_held", HZ | FA);
        idle_in(1'b1);
        cyc("release_go", FA);
        idle_in(1'b0);
        cyc("release_done", NONE);

        // Mispredict during DRAIN returns the FSM to IDLE.
        idle_in(1'b1);
        cyc("misp_f_idle", HZ);
        cyc("misp_f_drain2", HZ | FA);
        hz.execute_branch_mispredicted_in = 1'b1;
        cyc("misp_in_drain", MISP | FA);
        idle_in(1'b0);
        cyc("misp_f_after", NONE);

        // Reset mid-drain.
        idle_in(1'b1);
        cyc("rst_f_idle", HZ);
        cyc("rst_f_drain2", HZ | FA);
        reset = 1'b1;
        cyc("rst_mid_drain", RST);
        reset = 1'b0;
        idle_in(1'b0);
        cyc("rst_f_after", NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32_hazard_unit.md
Name: rv32_hazard_unit

Overview:
- Pipeline controller that sequences the stage registers of the in-order RV32 pipeline (fetch → decode → execute → mem → writeback).
- Generates per-stage stall and flush controls from three sources: decode's unregistered operand/fence indications, execute/mem destination info, and branch-mispredict and memory-busy status.
- Contains a fence-drain state machine that holds a FENCE in decode until the downstream stages have emptied.

Parameters:
- DRAIN_CYCLES, 3, cycles the fence is held in DRAIN (execute+mem+writeback depth); must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- decode_rs1_unreg_in  in  5  rs1 of instruction currently in decode
- decode_rs1_read_unreg_in  in  1  decode instruction reads rs1
- decode_rs2_unreg_in  in  5  rs2 of instruction in decode
- decode_rs2_read_unreg_in  in  1  decode instruction reads rs2
- decode_mem_fence_unreg_in  in  1  decode instruction is FENCE
- execute_rd_in  in  5  rd of instruction in execute
- execute_rd_write_in  in  1  execute instruction writes rd
- execute_mem_read_in  in  1  execute instruction is a load
- mem_rd_in  in  5  rd of instruction in mem
- mem_rd_write_in  in  1  mem instruction writes rd
- execute_branch_mispredicted_in  in  1  execute resolved a mispredicted branch/jump
- mem_busy_in  in  1  data bus has not completed the mem-stage access
- fetch_stall_out  out  1  hold fetch output register/PC
- fetch_flush_out  out  1  bubble into fetch output register
- decode_stall_out  out  1  hold decode output register
- decode_flush_out  out  1  bubble into decode output register
- execute_stall_out  out  1  hold execute output register
- execute_flush_out  out  1  bubble into execute output register
- mem_stall_out  out  1  hold mem output register
- fence_active_out  out  1  state != IDLE

Behaviour:
- All outputs are combinational from inputs plus registered state. Zero added latency.
- State: fsm ∈ {IDLE, DRAIN, RELEASE}; drain_cnt of width $clog2(DRAIN_CYCLES+1).
- Reset: fsm=IDLE, drain_cnt=0. While reset=1: all *_flush_out=1, all *_stall_out=0, fence_active_out=0. Reset mid-drain returns to IDLE immediately.
- Hazard terms (a read of x0 never matches):
  - raw_ex = execute_rd_write_in && execute_rd_in!=0 && ((rs1_read && rs1==execute_rd_in) || (rs2_read && rs2==execute_rd_in)).
  - raw_mem is defined the same way using mem_rd_*.
- Priority, highest first:
  1. mem_busy_in: fetch/decode/execute/mem stall=1; all flushes=0; FSM holds state and counter.
  2. mispredict (with !mem_busy): fetch_flush=1, decode_flush=1, no stalls; FSM → IDLE.
  3. load-use (execute_mem_read_in && raw_ex): fetch_stall=1, decode_flush=1.
  4. fence stall: fetch_stall=1, decode_flush=1. Asserted when fsm==DRAIN, or when fsm==IDLE && decode_mem_fence_unreg_in.
  5. Otherwise all stall/flush outputs are 0.
- FSM transitions (evaluated only when !mem_busy && !mispredict):
  - IDLE: if decode_mem_fence_unreg_in → DRAIN, drain_cnt=DRAIN_CYCLES-1.
  - DRAIN: if drain_cnt==0 → RELEASE; else drain_cnt decrements.
  - RELEASE: no fence stall. The fence advances into execute and the FSM goes → IDLE, but only if no load-use stall is active this cycle; otherwise it stays in RELEASE.
- A fence that is also load-use dependent: the load-use rule applies first; the FSM still enters DRAIN.
- execute_stall_out is asserted only by mem_busy_in. execute_flush_out is asserted only during reset.

Optional Feature:
- Macro: RV32_FORWARDING_EN.
- Defined: execute→execute and mem→execute forwarding exist. Only the load-use rule (raw_ex with execute_mem_read_in) stalls. mem_rd_* inputs are unused.
- Undefined: no forwarding. Any raw_ex or raw_mem causes fetch_stall=1, decode_flush=1 at priority 3. The register file provides write-through, so writeback is never checked.

Test Plan:
- Reset held 2 cycles, then released → during reset fetch/decode/execute flush=1 and stalls=0; after release all outputs=0 and fence_active_out=0.
- Forwarding on; load writes x5 in execute; decode rs1=5 with rs1_read=1 → exactly 1 cycle of fetch_stall=1 and decode_flush=1. Repeat with rs1=0 and rd=0 → no stall.
- Forwarding off; ALU op writes x7 in mem; decode rs2=7 → stall=1 for that cycle. Same stimulus with forwarding on → no stall.
- FENCE enters decode, DRAIN_CYCLES=3 → fence stall for 4 cycles (IDLE entry + 3 DRAIN), then 1 RELEASE cycle with no stall, then IDLE. fence_active_out=1 for 4 cycles.
- FENCE draining (drain_cnt=1) while mem_busy_in=1 for 3 cycles → all stalls=1 and drain_cnt frozen at 1. On release, the drain completes 2 cycles later.
- Mispredict coincident with load-use, then mispredict during DRAIN → fetch_flush=decode_flush=1 with fetch_stall=0; FSM returns to IDLE next cycle.
